// File: rtl/audio_pkg.sv
// Types and helpers shared by the serial-audio transmit path.
package audio_pkg;

    typedef enum logic [1:0] {
        FMT_I2S = 2'b00,
        FMT_LJ  = 2'b01,
        FMT_RJ  = 2'b10
    } fmt_t;

    function automatic int frame_bits(input int slot_w);
        return 2 * slot_w;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider: toggles sclk every HALF_DIV cycles and flags each falling transition.
module i2s_clkgen #(
    parameter int HALF_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    output logic sclk,
    output logic bit_tick
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);
    // Combinational so frame-start work lands on the same edge that drops sclk.
    assign bit_tick = div_wrap & sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2s_tx_param.sv
// Parametrised I2S / left- / right-justified transmitter with a one-deep sample
// holding register, same-cycle bypass at frame start and underrun counting.
module i2s_tx_param #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32,
    parameter int HALF_DIV = 8
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic [1:0]        fmt,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              dac_SCLK,
    output logic              dac_LRCK,
    output logic              dac_SDIN,
    output logic              underrun,
    output logic [7:0]        underrun_cnt
);
    import audio_pkg::*;

    localparam int FB = frame_bits(SLOT_W);
    localparam int BW = $clog2(FB);
    localparam logic [BW-1:0] BIT_LAST = BW'(FB - 1);

    logic              bit_tick, frame_start, xfer, hold_full;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [1:0]        fmt_q, fmt_nxt;
    logic [DATA_W-1:0] hold_l, hold_r, shift_l, shift_r, load_l, load_r;
    logic [DATA_W-1:0] slot_word, slot_shift;
    logic              slot_left, lrck_nxt, sdin_nxt;
    int                pos;

    i2s_clkgen #(.HALF_DIV(HALF_DIV)) u_clkgen (
        .clk      (clk_50MHz),
        .rst      (reset),
        .sclk     (dac_SCLK),
        .bit_tick (bit_tick)
    );

    assign frame_start  = bit_tick && (bit_cnt == BIT_LAST);
    assign sample_ready = ~hold_full;
    assign xfer         = sample_valid && sample_ready;
    assign bit_nxt      = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);

    // Sample and format that will be in effect after this edge; an empty
    // holding register with no transfer leaves the previous pair to replay.
    always_comb begin
        load_l  = shift_l;
        load_r  = shift_r;
        fmt_nxt = fmt_q;
        if (frame_start) begin
            fmt_nxt = fmt;
            if (hold_full) begin
                load_l = hold_l;
                load_r = hold_r;
            end else if (xfer) begin
                load_l = l_data;
                load_r = r_data;
            end
        end
    end

    always_comb begin
        slot_left  = int'(bit_nxt) < SLOT_W;
        pos        = slot_left ? int'(bit_nxt) : int'(bit_nxt) - SLOT_W;
        slot_word  = slot_left ? load_l : load_r;
        slot_shift = '0;
        lrck_nxt   = ~slot_left;
        sdin_nxt   = 1'b0;
        case (fmt_nxt)
            FMT_LJ: begin
                lrck_nxt = slot_left;
                if (pos < DATA_W) begin
                    slot_shift = slot_word >> (DATA_W - 1 - pos);
                    sdin_nxt   = slot_shift[0];
                end
            end
            FMT_RJ: begin
                lrck_nxt = slot_left;
                if (pos >= SLOT_W - DATA_W) begin
                    slot_shift = slot_word >> (SLOT_W - 1 - pos);
                    sdin_nxt   = slot_shift[0];
                end
            end
            default: begin
                if (pos >= 1 && pos <= DATA_W) begin
                    slot_shift = slot_word >> (DATA_W - pos);
                    sdin_nxt   = slot_shift[0];
                end
            end
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            bit_cnt      <= BIT_LAST;
            fmt_q        <= FMT_I2S;
            hold_full    <= 1'b0;
            hold_l       <= '0;
            hold_r       <= '0;
            shift_l      <= '0;
            shift_r      <= '0;
            dac_LRCK     <= 1'b1;
            dac_SDIN     <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= 1'b0;
            if (bit_tick) begin
                bit_cnt  <= bit_nxt;
                dac_LRCK <= lrck_nxt;
                dac_SDIN <= sdin_nxt;
            end
            if (frame_start) begin
                fmt_q     <= fmt_nxt;
                shift_l   <= load_l;
                shift_r   <= load_r;
                hold_full <= 1'b0;
                if (!hold_full && !xfer) begin
                    underrun <= 1'b1;
                    if (underrun_cnt != 8'hFF)
                        underrun_cnt <= underrun_cnt + 8'd1;
                end
            end else if (xfer) begin
                hold_l    <= l_data;
                hold_r    <= r_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_param.sv
// Self-checking bench for i2s_tx_param (DATA_W=16, SLOT_W=32, HALF_DIV=2).
module tb_i2s_tx_param;

    localparam int DATA_W   = 16;
    localparam int SLOT_W   = 32;
    localparam int HALF_DIV = 2;

    logic        clk_50MHz = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  fmt = 2'b00;
    logic [15:0] l_data = '0;
    logic [15:0] r_data = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, dac_SCLK, dac_LRCK, dac_SDIN, underrun;
    logic [7:0]  underrun_cnt;

    i2s_tx_param #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .HALF_DIV(HALF_DIV)) dut (
        .clk_50MHz    (clk_50MHz),
        .reset        (reset),
        .fmt          (fmt),
        .l_data       (l_data),
        .r_data       (r_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .dac_SCLK     (dac_SCLK),
        .dac_LRCK     (dac_LRCK),
        .dac_SDIN     (dac_SDIN),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_sdin(input logic [1:0] f, input logic [15:0] s, input int p);
        logic [15:0] t;
        t = '0;
        if (f == 2'b01) begin
            if (p < 16) t = s >> (15 - p);
        end else if (f == 2'b10) begin
            if (p >= 16) t = s >> (31 - p);
        end else begin
            if (p >= 1 && p <= 16) t = s >> (16 - p);
        end
        return t[0];
    endfunction

    function automatic logic exp_lrck(input logic [1:0] f, input logic left);
        return (f == 2'b01 || f == 2'b10) ? left : ~left;
    endfunction

    // Model: clk edges since release; bit ticks every 4 clk from edge 4, frames every 256 clk.
    int          n;
    logic        m_full, m_under;
    logic [15:0] m_hl, m_hr, m_cl, m_cr;
    logic [1:0]  m_fmt;
    logic [7:0]  m_ucnt;

    always @(posedge clk_50MHz or posedge reset) begin
        logic xfer, fs;
        if (reset) begin
            n = 0; m_full = 0; m_under = 0;
            m_hl = '0; m_hr = '0; m_cl = '0; m_cr = '0;
            m_fmt = 2'b00; m_ucnt = '0;
        end else begin
            xfer = sample_valid && !m_full;
            n++;
            fs = (n >= 4) && (((n - 4) % 256) == 0);
            m_under = 0;
            if (fs) begin
                m_fmt = fmt;
                if (m_full) begin
                    m_cl = m_hl; m_cr = m_hr; m_full = 0;
                end else if (xfer) begin
                    m_cl = l_data; m_cr = r_data;
                end else begin
                    m_under = 1;
                    if (m_ucnt != 8'hFF) m_ucnt = m_ucnt + 8'd1;
                end
            end else if (xfer) begin
                m_hl = l_data; m_hr = r_data; m_full = 1;
            end
        end
    end

    always @(negedge clk_50MHz) begin
        int b, p;
        logic left;
        if (!reset) begin
            b    = (n < 4) ? 63 : (((n - 4) / 4) % 64);
            p    = b % 32;
            left = (b < 32);
            check("sclk", 64'(dac_SCLK), 64'(((n / 2) % 2) != 0));
            check("lrck", 64'(dac_LRCK), 64'(exp_lrck(m_fmt, left)));
            check("sdin", 64'(dac_SDIN), 64'(exp_sdin(m_fmt, left ? m_cl : m_cr, p)));
            check("ready", 64'(sample_ready), 64'(!m_full));
            check("underrun", 64'(underrun), 64'(m_under));
            check("underrun_cnt", 64'(underrun_cnt), 64'(m_ucnt));
        end
    end

    int under_pulses = 0;
    always @(negedge clk_50MHz) if (!reset && underrun) under_pulses++;

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        int k;
        k = 0;
        l_data = l; r_data = r; sample_valid = 1'b1;
        while (!sample_ready && k < 600) begin
            @(negedge clk_50MHz);
            k++;
        end
        if (k >= 600) check("send_timeout", 64'(k), 64'd0);
        @(negedge clk_50MHz);
        sample_valid = 1'b0;
    endtask

    task automatic capture(input bit drop_valid, output logic [63:0] sd, output logic [63:0] lr,
                           output logic fs_under, output logic fs_ready);
        int k;
        k = 0;
        sd = '0; lr = '0;
        @(negedge clk_50MHz);
        while ((n % 256) != 4 && k < 600) begin
            @(negedge clk_50MHz);
            k++;
        end
        if (k >= 600) check("capture_timeout", 64'(k), 64'd0);
        if (drop_valid) sample_valid = 1'b0;
        fs_under = underrun;
        fs_ready = sample_ready;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) repeat (4) @(negedge clk_50MHz);
            sd[63 - i] = dac_SDIN;
            lr[63 - i] = dac_LRCK;
        end
    endtask

    initial begin
        #(2_400_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] sd, lr;
        logic        u, rd;
        logic [3:0]  sc_v, lr_v;
        int          p0, k;

        repeat (3) @(negedge clk_50MHz);
        fmt   = 2'b01;
        reset = 1'b0;

        // Left-justified
        send(16'hA5C3, 16'h0001);
        capture(0, sd, lr, u, rd);
        check("lj_sdin", sd, 64'hA5C30000_00010000);
        check("lj_lrck", lr, 64'hFFFFFFFF_00000000);

        // I2S
        fmt = 2'b00;
        send(16'hA5C3, 16'h0001);
        capture(0, sd, lr, u, rd);
        check("i2s_sdin", sd, 64'h52E18000_00008000);
        check("i2s_lrck", lr, 64'h00000000_FFFFFFFF);

        // Right-justified
        fmt = 2'b10;
        send(16'h8000, 16'h0001);
        capture(0, sd, lr, u, rd);
        check("rj_sdin", sd, 64'h00008000_00000001);
        check("rj_lrck", lr, 64'hFFFFFFFF_00000000);

        // Bypass: valid offered only in the frame-start cycle
        k = 0;
        while ((n % 256) != 3 && k < 600) begin
            @(negedge clk_50MHz);
            k++;
        end
        fmt = 2'b01;
        l_data = 16'h1234; r_data = 16'h5678; sample_valid = 1'b1;
        capture(1, sd, lr, u, rd);
        check("bypass_sdin", sd, 64'h12340000_56780000);
        check("bypass_underrun", 64'(u), 64'd0);
        check("bypass_ready", 64'(rd), 64'd1);

        // Underrun: replay and saturation
        p0 = under_pulses;
        capture(0, sd, lr, u, rd);
        check("replay_sdin", sd, 64'h12340000_56780000);
        check("replay_underrun", 64'(u), 64'd1);
        check("replay_pulses", 64'(under_pulses - p0), 64'd1);
        p0 = under_pulses;
        repeat (256 * 256) @(negedge clk_50MHz);
        check("pulses_per_frame", 64'(under_pulses - p0), 64'd256);
        check("ucnt_sat", 64'(underrun_cnt), 64'd255);

        // Reset mid right slot with a pending sample
        repeat (170) @(negedge clk_50MHz);
        send(16'hBEEF, 16'hCAFE);
        fmt = 2'b00;
        #2 reset = 1'b1;
        #1;
        check("rst_sclk", 64'(dac_SCLK), 64'd0);
        check("rst_lrck", 64'(dac_LRCK), 64'd1);
        check("rst_sdin", 64'(dac_SDIN), 64'd0);
        check("rst_ready", 64'(sample_ready), 64'd1);
        check("rst_underrun", 64'(underrun), 64'd0);
        check("rst_ucnt", 64'(underrun_cnt), 64'd0);
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_50MHz);
            sc_v[3 - i] = dac_SCLK;
            lr_v[3 - i] = dac_LRCK;
        end
        check("post_rst_sclk", 64'(sc_v), 64'(4'b0110));
        check("post_rst_lrck", 64'(lr_v), 64'(4'b1110));
        capture(0, sd, lr, u, rd);
        check("pending_dropped", sd, 64'd0);
        check("post_rst_ucnt", 64'(underrun_cnt), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_tx_param.md
# i2s_tx_param

Parametrised I2S/serial-audio transmitter and successor to the fixed 16-bit stereo `audio_top` serializer. It sits between the guest core's `DAC_L`/`DAC_R` sample outputs and the board DAC pins `I2S_BCK`, `I2S_LRCK` and `I2S_DATA`. It generalises sample width, slot width and bit-clock rate, and adds:
- runtime-selectable frame format (I2S, left-justified, right-justified);
- a valid/ready sample handshake with a one-deep holding register;
- underrun detection and counting.

## Interface
Parameters:
- `DATA_W`, 16: sample width in bits; must satisfy 1 ≤ DATA_W ≤ SLOT_W-1.
- `SLOT_W`, 32: bit-clock periods per channel slot; a frame is 2*SLOT_W bits.
- `HALF_DIV`, 8: clk cycles per SCLK half-period (≥1). At 50 MHz with defaults, SCLK = 3.125 MHz and fs = 48.83 kHz.

Ports:
- `clk_50MHz`, in, 1: the only clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `fmt`, in, 2: frame format, sampled at frame start only.
- `l_data`, in, DATA_W: left sample, two's complement.
- `r_data`, in, DATA_W: right sample, two's complement.
- `sample_valid`, in, 1: `l_data`/`r_data` pair is offered.
- `sample_ready`, out, 1: holding register empty; a transfer occurs when valid & ready.
- `dac_SCLK`, out, 1: bit clock.
- `dac_LRCK`, out, 1: word select.
- `dac_SDIN`, out, 1: serial data.
- `underrun`, out, 1: one-cycle pulse at a frame start that found no sample.
- `underrun_cnt`, out, 8: saturating count of underruns.

## Operation
- Formats, from the shared `fmt_t` type:
  - FMT_I2S = 00. 11 is reserved and behaves as FMT_I2S.
  - FMT_LJ = 01.
  - FMT_RJ = 10.
- Divider:
  - `div_cnt` counts 0..HALF_DIV-1; `dac_SCLK` toggles when `div_cnt` = HALF_DIV-1.
  - A toggle to 0 is a "bit tick". All `dac_LRCK`/`dac_SDIN` changes happen on bit ticks, i.e. on the SCLK falling edge.
- Bit counter:
  - `bit_cnt` runs 0..2*SLOT_W-1 and advances on each bit tick.
  - Slot position p = `bit_cnt` mod SLOT_W. The left slot is `bit_cnt` < SLOT_W.
  - Frame start is the bit tick at which `bit_cnt` becomes 0.
- Frame start, all in that same clk cycle:
  - `fmt` is latched.
  - If the holding register is full: its content moves to the shift registers and `sample_ready` rises next cycle.
  - If the holding register is empty and valid & ready is asserted in that cycle: bypass. The offered pair loads directly into the shift registers, the holding register stays empty, and no underrun is raised.
  - If the holding register is empty and there is no transfer: the previous pair is replayed, `underrun` pulses, and `underrun_cnt` increments, saturating at 255.
- Outside frame start, valid & ready writes the holding register; `sample_ready` drops on the next cycle.
- LRCK:
  - I2S: 0 for the left slot, 1 for the right slot.
  - LJ and RJ: 1 for the left slot, 0 for the right slot.
- SDIN within a slot, carrying that slot's sample; every other position outputs 0:
  - I2S: bit DATA_W-p for 1 ≤ p ≤ DATA_W.
  - LJ: bit DATA_W-1-p for p < DATA_W.
  - RJ: bit SLOT_W-1-p for p ≥ SLOT_W-DATA_W.

## Timing
- Reset values:
  - `dac_SCLK` = 0, `dac_LRCK` = 1, `dac_SDIN` = 0.
  - `sample_ready` = 1, `underrun` = 0, `underrun_cnt` = 0.
  - Holding register empty, shift registers 0, `bit_cnt` = 2*SLOT_W-1, `div_cnt` = 0, latched format FMT_I2S.
- The first frame start occurs 2*HALF_DIV clk after reset release.
- Reset asserted mid-frame clears everything immediately and discards any pending sample.
- All outputs are registered; `dac_SDIN` and `dac_LRCK` change in the same clk as the SCLK falling transition.
- Latency from accept to MSB on `dac_SDIN`:
  - At least the wait to the next frame start.
  - Plus 1 bit period in I2S mode.
  - Plus SLOT_W-DATA_W bit periods in RJ mode.
- A `fmt` change mid-frame takes effect only at the next frame start.

## Structure
- Shared package `audio_pkg`:
  - `fmt_t` enum holding FMT_I2S, FMT_LJ and FMT_RJ.
  - Helper function for frame bit count, 2*SLOT_W.
- Sub-module `i2s_clkgen`, parameter HALF_DIV: owns `div_cnt`, drives `dac_SCLK`, and emits a one-cycle `bit_tick`.
- Top level `i2s_tx_param` holds `bit_cnt`, the holding register, the shift/select logic and the underrun counter.

## Test plan
All scenarios use DATA_W=16, SLOT_W=32, HALF_DIV=2; a frame is 256 clk.
1. FMT_LJ, feed L=16'hA5C3, R=16'h0001 before the first frame start. Required:
   - LRCK = 1 for 32 bits, then 0.
   - SDIN = 1010010111000011 followed by 16 zeros, then 15 zeros, a 1, and 16 zeros.
2. FMT_I2S, same data. Required: LRCK low during the left slot; MSB of 16'hA5C3 at p=1; p=0 and p=17..31 output 0.
3. FMT_RJ, L=16'h8000. Required: SDIN = 0 for p=0..15, 1 at p=16, 0 for p=17..31.
4. No sample after the first. Required:
   - `underrun` pulses exactly once per frame.
   - The previous pair is replayed.
   - After 300 frames, `underrun_cnt` = 255.
5. Holding register empty and `sample_valid` asserted exactly in the frame-start cycle. Required: the data appears in that frame, `underrun` stays 0, and `sample_ready` stays 1.
6. Assert `reset` mid-right-slot with a pending sample. Required:
   - All outputs return to their reset values in the same cycle.
   - The pending sample is never transmitted.
   - The next frame start comes 4 clk after release.
